// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: datapath width, funct3/funct7 encodings and the
// execute-unit state encoding.
package riscv_m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, operands
// loaded as magnitudes by the parent, which also owns sequencing and signs.
module muldiv_div_core #(
    parameter int XLEN = riscv_m_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // The partial remainder always stays below the divisor, so the shifted
    // value needs only one extra bit and the difference fits in XLEN bits.
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        fits    = shifted >= {1'b0, div_q};
        diff    = shifted[XLEN-1:0] - div_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            div_q  <= divisor;
        end else if (step) begin
            rem_q  <= fits ? diff : shifted[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], fits};
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M execute unit: stalls the pipeline while a multiply or
// divide is in flight and presents the result in the release cycle.
module ex_muldiv_unit #(
    parameter int XLEN      = riscv_m_pkg::XLEN,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    import riscv_m_pkg::*;

    localparam int              CNT_W    = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic             q_neg_q, r_neg_q;

    logic             accept, op_is_div, div_signed, a_neg, b_neg;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  a_mag, b_mag, special_res;
    logic             div_load, div_step, result_we;
    logic [XLEN-1:0]  result_d, quotient, remainder, fix_res, mul_res;
    logic [4:0]       rd_d;
    logic             mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] a_wide, b_wide, product;

    always_comb begin
        accept      = (state == ST_IDLE) && valid_i && !flush_i;
        op_is_div   = funct3_i[2];
        div_signed  = !funct3_i[0];
        a_neg       = div_signed & rs1_val_i[XLEN-1];
        b_neg       = div_signed & rs2_val_i[XLEN-1];
        a_mag       = a_neg ? -rs1_val_i : rs1_val_i;
        b_mag       = b_neg ? -rs2_val_i : rs2_val_i;
        div_zero    = (rs2_val_i == '0);
        div_ovf     = div_signed && (rs1_val_i == INT_MIN) && (rs2_val_i == '1);
        special     = op_is_div && (div_zero || div_ovf);
        if (div_zero) special_res = funct3_i[1] ? rs1_val_i : '1;
        else          special_res = funct3_i[1] ? '0 : INT_MIN;
    end

    // Extending the 33-bit signed operands to 64 bits and keeping the low 64
    // product bits gives exactly the 33x33 signed product's useful bits.
    always_comb begin
        mul_a_signed = (op_q != F3_MULHU);
        mul_b_signed = (op_q == F3_MUL) || (op_q == F3_MULH);
        a_wide       = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
        b_wide       = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
        product      = a_wide * b_wide;
        mul_res      = (op_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        fix_res      = op_q[1] ? (r_neg_q ? -remainder : remainder)
                               : (q_neg_q ? -quotient  : quotient);
    end

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;
        result_we  = 1'b0;
        result_d   = mul_res;
        rd_d       = rd_q;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    busy_o = 1'b1;
                    if (!op_is_div) begin
                        next_state = ST_MUL;
                    end else if (special) begin
                        next_state = ST_DONE;
                        result_we  = 1'b1;
                        result_d   = special_res;
                        rd_d       = rd_i;
                    end else begin
                        next_state = ST_DIV;
                        div_load   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                busy_o     = 1'b1;
                next_state = ST_DONE;
                result_we  = 1'b1;
            end
            ST_DIV: begin
                busy_o   = 1'b1;
                div_step = 1'b1;
                if (cnt == CNT_LAST) next_state = ST_FIX;
            end
            ST_FIX: begin
                busy_o     = 1'b1;
                next_state = ST_DONE;
                result_we  = 1'b1;
                result_d   = fix_res;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (flush_i) begin
            next_state = ST_IDLE;
            done_o     = 1'b0;
            div_step   = 1'b0;
            result_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            cnt <= (state == ST_DIV && !flush_i) ? cnt + 1'b1 : '0;
            if (accept) begin
                op_q    <= funct3_i;
                rd_q    <= rd_i;
                a_q     <= rs1_val_i;
                b_q     <= rs2_val_i;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
            end
            if (result_we) begin
                result_o <= result_d;
                rd_o     <= rd_d;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush and
// reset scenarios, then random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;
    import riscv_m_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_val_i, rs2_val_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .funct3_i  (funct3_i),
        .rs1_val_i (rs1_val_i),
        .rs2_val_i (rs2_val_i),
        .rd_i      (rd_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_o      (rd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            F3_MUL:    begin p = sa * sb;           return p[31:0];  end
            F3_MULH:   begin p = sa * sb;           return p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub;           return p[63:32]; end
            F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Starts just after a rising edge (cycle T); ends just after a rising edge.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic [4:0] rd);
        int   lat;
        bit   stall_ok;
        bit   seen;
        valid_i   = 1'b1;
        funct3_i  = f3;
        rs1_val_i = a;
        rs2_val_i = b;
        rd_i      = rd;
        @(negedge clk);
        check({tag, " busy@T"}, 32'(busy_o), 32'd1);
        lat      = 0;
        seen     = 1'b0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            rs1_val_i = $urandom;
            rs2_val_i = $urandom;
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                lat  = k;
            end else if (busy_o !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(ref_latency(f3, a, b)));
        check({tag, " stall"}, 32'(stall_ok), 32'd1);
        check({tag, " result"}, result_o, exp);
        check({tag, " rd"}, 32'(rd_o), 32'(rd));
        check({tag, " busy@done"}, 32'(busy_o), 32'd0);
        last_res = exp;
        last_rd  = rd;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        check({tag, " single done"}, 32'(done_o), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic flush_div(input bit back_to_back);
        bit extra_done;
        valid_i   = 1'b1;
        funct3_i  = F3_DIV;
        rs1_val_i = 32'd1000;
        rs2_val_i = 32'd3;
        rd_i      = 5'd9;
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(negedge clk);
        check("flush done@T+10", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        if (back_to_back) begin
            run_op("mul after flush", F3_MUL, 32'd6, 32'd7, 32'd42, 5'd3);
        end else begin
            @(negedge clk);
            check("flush busy@T+11", 32'(busy_o), 32'd0);
            check("flush result hold", result_o, last_res);
            check("flush rd hold", 32'(rd_o), 32'(last_rd));
            extra_done = 1'b0;
            repeat (36) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (done_o) extra_done = 1'b1;
            end
            check("flush no done", 32'(extra_done), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir[12];

    initial begin
        bit          spurious;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [31:0] edges[4];

        dir[0]  = '{"MUL",         F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir[1]  = '{"MULHU",       F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir[2]  = '{"MULH",        F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        dir[3]  = '{"MULHSU",      F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir[4]  = '{"DIVU by 0",   F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        dir[5]  = '{"REM by 0",    F3_REM,    32'h1234,       32'd0,         32'h1234};
        dir[6]  = '{"DIV ovf",     F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        dir[7]  = '{"REM ovf",     F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        dir[8]  = '{"DIV -7/2",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        dir[9]  = '{"REM -7%2",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        dir[10] = '{"DIVU 100/7",  F3_DIVU,   32'd100,        32'd7,         32'd14};
        dir[11] = '{"REMU 100%7",  F3_REMU,   32'd100,        32'd7,         32'd2};
        edges   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF};

        rst       = 1'b0;
        valid_i   = 1'b0;
        funct3_i  = '0;
        rs1_val_i = '0;
        rs2_val_i = '0;
        rd_i      = '0;
        flush_i   = 1'b0;
        #2;
        check("reset result", result_o, 32'h0);
        check("reset rd", 32'(rd_o), 32'h0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(dir[i].tag, dir[i].f3, dir[i].a, dir[i].b, dir[i].exp, 5'(i + 1));

        flush_div(1'b0);
        flush_div(1'b1);

        // Asynchronous reset in the middle of a divide.
        valid_i   = 1'b1;
        funct3_i  = F3_DIV;
        rs1_val_i = 32'd12345;
        rs2_val_i = 32'd17;
        rd_i      = 5'd20;
        repeat (5) @(posedge clk);
        #2;
        valid_i = 1'b0;
        rst     = 1'b0;
        #1;
        check("async rst result", result_o, 32'h0);
        check("async rst rd", 32'(rd_o), 32'h0);
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        spurious = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done_o || busy_o) spurious = 1'b1;
        end
        check("post-reset quiet", 32'(spurious), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                2: b = 32'h0;
                default: begin
                    a = edges[$urandom_range(0, 3)];
                    b = edges[$urandom_range(0, 3)];
                end
            endcase
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, ref_result(f3, a, b),
                   5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M execute unit in the EX stage.
- Consumes the forwarded operands: the outputs of the EX operand muxes that ForwardAE/ForwardBE steer.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- While an operation is in flight it raises a stall request to pipeline control. It presents the result for EX/MEM capture in the cycle the pipeline is released.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
DIV_STEPS, 32, divider iterations, one quotient bit per cycle; must equal XLEN.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  reset, asynchronous, active-low
valid_i  input  1  EX holds an M-extension op (opcode OP, funct7=0000001)
funct3_i  input  3  M-op select per RV32M encoding
rs1_val_i  input  32  forwarded operand A (post ForwardAE mux)
rs2_val_i  input  32  forwarded operand B (post ForwardBE mux)
rd_i  input  5  destination register of the EX instruction
flush_i  input  1  kill in-flight op (branch redirect/trap)
busy_o  output  1  stall request: freeze PC/IF-ID/ID-EX, bubble into EX/MEM
done_o  output  1  one-cycle pulse, result_o/rd_o valid
result_o  output  32  32-bit result
rd_o  output  5  destination register of the completed op

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, result_o=0, rd_o=0, done_o=0, busy_o=0. Reset mid-operation abandons the op.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: in IDLE when valid_i=1 and flush_i=0. Operands, funct3 and rd are latched at the clock edge ending the accept cycle T.
- busy_o is combinational:
  - busy_o = (IDLE & valid_i & ~flush_i) | MUL | DIV | FIX.
  - busy_o=0 in DONE.
- done_o = DONE & ~flush_i. In DONE the pipeline advances and EX/MEM captures result_o.
- DONE always returns to IDLE next cycle. valid_i seen in DONE belongs to the completing instruction and is never re-accepted.
- Multiply:
  - IDLE -> MUL -> DONE. done_o at T+2; busy for T, T+1.
  - MUL uses a signed 33x33 product: operands are sign- or zero-extended per funct3. MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Magnitudes are taken at accept for signed ops.
  - DIV runs DIV_STEPS restoring iterations, cycles T+1..T+32. FIX applies sign correction at T+33. DONE at T+34, done_o at T+34.
  - Signs: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- Divide special cases (IDLE -> DONE directly, done_o at T+1):
  - divisor=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result the dividend.
  - signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Flush:
  - flush_i=1 in any state: next state IDLE, counter cleared, no done_o pulse, result_o/rd_o hold their previous value.
  - flush_i in IDLE blocks accept that cycle.
- Hold: result_o/rd_o change only when entering DONE.
- rs1/rs2 changes after accept have no effect.

Decomposition:
- Shared package riscv_m_pkg:
  - XLEN.
  - funct3 constants F3_MUL..F3_REMU.
  - FUNCT7_MULDIV.
  - State encoding typedef.
- One sub-module, muldiv_div_core: restoring-divider datapath.
  - Registers remainder and quotient.
  - Performs one shift/subtract step per enable.
  - Exposes the final unsigned quotient and remainder.
  - The parent owns the FSM, sign handling, special cases and the multiplier.

Test Plan:
- MUL 7 * 0xFFFFFFFD at T -> result_o=0xFFFFFFEB, rd_o=rd_i, done_o only at T+2, busy_o high at T and T+1.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2. Each: busy_o 34 cycles, done_o at T+34.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each: done_o at T+1.
- flush_i pulse at T+10 of a DIV -> IDLE at T+11, busy_o=0, no done_o, result_o unchanged; back-to-back MUL accepted at T+11, done at T+13.
- Reset and hold:
  - rst driven low asynchronously at T+5 of a DIV -> outputs 0 before the next edge.
  - After release, no spurious done_o.
  - valid_i held high through DONE -> exactly one done_o per instruction.
